// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx
// Receive-side deserializer. Shifts the serial stream in MSB first on clk_32f,
// finds byte alignment from the 0xBC comma, locks after BC_LOCK aligned commas
// and then presents each aligned payload byte for one 8-cycle byte period.
// COMMA and IDLE characters are stripped: they drop valid_out while data_out
// keeps the last payload byte.
//
// Output semantics: there is no backpressure. data_out/valid_out change only
// on the edge that completes an aligned byte, and byte_strobe is high for the
// single cycle that follows that edge. A consumer samples data_out when
// byte_strobe is high and treats it as payload only if valid_out is high.
module serial_paralelo_rx #(
  parameter logic [7:0]  COMMA     = 8'hBC,
  parameter logic [7:0]  IDLE      = 8'h7C,
  parameter int unsigned BC_LOCK   = 4,
  parameter int unsigned LOSE_LOCK = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       locked_out,
  output logic       active_out
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2,
    ACTIVE  = 2'd3
  } state_t;

  localparam logic [3:0] BC_LOCK_C   = 4'(BC_LOCK);
  localparam logic [3:0] LOSE_LOCK_C = 4'(LOSE_LOCK);

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] cc_q, cc_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;

  // Window including the bit being sampled this edge; every decision uses it
  // so the aligned byte is acted on at its own 8th bit edge.
  logic [7:0] nxt;
  logic [3:0] cc_inc;
  logic       boundary;

  // Next-state, alignment counting and output updates.
  always_comb begin
    nxt       = {sr_q[6:0], data_in};
    cc_inc    = (cc_q == 4'hF) ? cc_q : cc_q + 4'd1;
    boundary  = (bit_cnt_q == 3'd7) && (state_q != SEARCH);
    state_d   = state_q;
    sr_d      = nxt;
    bit_cnt_d = bit_cnt_q + 3'd1;
    cc_d      = cc_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = boundary;

    case (state_q)
      SEARCH: begin
        // Free-running bit search: any comma window sets the byte phase.
        if (nxt == COMMA) begin
          state_d   = LOCKING;
          bit_cnt_d = 3'd0;
          cc_d      = 4'd1;
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (nxt == COMMA) begin
            cc_d = cc_inc;
            if (cc_inc == BC_LOCK_C) begin
              state_d = LOCKED;
              cc_d    = 4'd0;
            end
          end else begin
            state_d = SEARCH;
            cc_d    = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (nxt == IDLE) begin
            state_d = ACTIVE;
            valid_d = 1'b0;
          end else if (nxt != COMMA) begin
            state_d = ACTIVE;
            data_d  = nxt;
            valid_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // Alignment is frozen here; a run of commas means the transmitter
        // went inactive, so fall back to LOCKED without realigning.
        if (boundary) begin
          if (nxt == COMMA) begin
            valid_d = 1'b0;
            cc_d    = cc_inc;
            if (cc_inc == LOSE_LOCK_C) begin
              state_d = LOCKED;
              cc_d    = 4'd0;
            end
          end else if (nxt == IDLE) begin
            valid_d = 1'b0;
            cc_d    = 4'd0;
          end else begin
            data_d  = nxt;
            valid_d = 1'b1;
            cc_d    = 4'd0;
          end
        end
      end
      default: begin
        state_d = SEARCH;
        cc_d    = 4'd0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= 8'd0;
      bit_cnt_q <= 3'd0;
      cc_q      <= 4'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      cc_q      <= cc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign locked_out  = (state_q == LOCKED) || (state_q == ACTIVE);
  assign active_out  = (state_q == ACTIVE);

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx
// Bench for the serial-to-parallel receiver: drives MSB-first bytes on the
// falling edge, samples outputs 1 ns after the rising edge, and keeps a queue
// of expected payload bytes that is drained as aligned bytes come out.
module tb_serial_paralelo_rx;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       locked_out;
  logic       active_out;

  int         n_checks   = 0;
  int         n_pass     = 0;
  int         strobe_cnt = 0;
  logic       hold_en    = 1'b0;
  logic [7:0] prev_data  = 8'd0;
  logic       prev_valid = 1'b0;
  logic [7:0] last_payload = 8'd0;
  logic [7:0] exp_q[$];

  serial_paralelo_rx dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .locked_out (locked_out),
    .active_out (active_out)
  );

  // Clock block
  always #5 clk_32f = ~clk_32f;

  // Outputs may only move on a strobe cycle; also counts strobe pulses.
  always @(negedge clk_32f) begin
    if (hold_en) begin
      n_checks++;
      if (!byte_strobe && (data_out !== prev_data || valid_out !== prev_valid))
        $display("FAIL hold data_out=%h/%h valid_out=%b/%b changed without strobe at %0t",
                 data_out, prev_data, valid_out, prev_valid, $time);
      else
        n_pass++;
    end
    prev_data  = data_out;
    prev_valid = valid_out;
    if (byte_strobe === 1'b1) strobe_cnt++;
  end

  // Time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Drives a byte and returns just after the edge that samples its last bit.
  task automatic send_and_wait(input logic [7:0] b);
    send_byte(b);
    @(posedge clk_32f);
    #1;
  endtask

  task automatic do_reset();
    hold_en = 1'b0;
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset = 1'b0;
    @(negedge clk_32f);
    hold_en = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] c;
    c = 8'hBC;
    hold_en = 1'b0;
    reset   = 1'b1;
    // Commas while in reset must not be seen.
    for (int k = 0; k < 3; k++)
      for (int i = 7; i >= 0; i--) begin
        @(negedge clk_32f);
        data_in = c[i];
      end
    @(posedge clk_32f);
    #1;
    n_checks++; if (data_out !== 8'h00) $display("FAIL rst_data data_out=%h exp=00", data_out); else n_pass++;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL rst_valid valid_out=%b exp=0", valid_out); else n_pass++;
    n_checks++; if (byte_strobe !== 1'b0) $display("FAIL rst_strobe byte_strobe=%b exp=0", byte_strobe); else n_pass++;
    n_checks++; if (locked_out !== 1'b0) $display("FAIL rst_locked locked_out=%b exp=0", locked_out); else n_pass++;
    n_checks++; if (active_out !== 1'b0) $display("FAIL rst_active active_out=%b exp=0", active_out); else n_pass++;
    @(negedge clk_32f);
    data_in = 1'b0;
    reset   = 1'b0;
    @(negedge clk_32f);
    hold_en = 1'b1;
  endtask

  task automatic test_lock();
    logic exp_l;
    for (int k = 1; k <= 4; k++) begin
      send_and_wait(8'hBC);
      exp_l = (k == 4);
      n_checks++; if (locked_out !== exp_l) $display("FAIL lock_c%0d locked_out=%b exp=%b", k, locked_out, exp_l); else n_pass++;
      n_checks++; if (byte_strobe !== (k != 1)) $display("FAIL lock_strobe_c%0d byte_strobe=%b exp=%b", k, byte_strobe, (k != 1)); else n_pass++;
    end
    n_checks++; if (active_out !== 1'b0) $display("FAIL lock_active active_out=%b exp=0", active_out); else n_pass++;
  endtask

  task automatic test_random_phase();
    logic       bits[$];
    logic [7:0] sr;
    logic [7:0] comma_v;
    logic       ok;
    logic       b;
    int         nb;
    int         c0;
    comma_v = 8'hBC;
    do_reset();
    // Reject noise that would form a comma before the first real one ends.
    do begin
      bits.delete();
      nb = $urandom_range(3, 21);
      for (int i = 0; i < nb; i++) bits.push_back(1'($urandom_range(0, 1)));
      sr = 8'd0;
      ok = 1'b1;
      for (int i = 0; i < nb + 7; i++) begin
        b  = (i < nb) ? bits[i] : comma_v[7 - (i - nb)];
        sr = {sr[6:0], b};
        if (sr == comma_v) ok = 1'b0;
      end
    end while (!ok);
    c0 = strobe_cnt;
    for (int i = 0; i < nb; i++) send_bit(bits[i]);
    for (int k = 1; k <= 4; k++) begin
      send_and_wait(8'hBC);
      n_checks++; if (locked_out !== (k == 4)) $display("FAIL phase_lock_c%0d nb=%0d locked_out=%b exp=%b", k, nb, locked_out, (k == 4)); else n_pass++;
    end
    n_checks++; if (byte_strobe !== 1'b1) $display("FAIL phase_strobe byte_strobe=%b exp=1", byte_strobe); else n_pass++;
    n_checks++; if (strobe_cnt - c0 !== 2) $display("FAIL phase_strobe_cnt count=%0d exp=2", strobe_cnt - c0); else n_pass++;
  endtask

  task automatic test_payload();
    logic [7:0] e;
    send_and_wait(8'h7C);
    n_checks++; if (active_out !== 1'b1) $display("FAIL pay_active active_out=%b exp=1", active_out); else n_pass++;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL pay_idle_valid valid_out=%b exp=0", valid_out); else n_pass++;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    for (int k = 0; k < 2; k++) begin
      send_and_wait(exp_q[0]);
      e = exp_q.pop_front();
      last_payload = e;
      n_checks++; if (data_out !== e) $display("FAIL pay_data%0d data_out=%h exp=%h", k, data_out, e); else n_pass++;
      n_checks++; if (valid_out !== 1'b1) $display("FAIL pay_valid%0d valid_out=%b exp=1", k, valid_out); else n_pass++;
      n_checks++; if (byte_strobe !== 1'b1) $display("FAIL pay_strobe%0d byte_strobe=%b exp=1", k, byte_strobe); else n_pass++;
    end
  endtask

  task automatic test_locking_abort();
    int c1;
    do_reset();
    send_and_wait(8'hBC);
    send_and_wait(8'hBC);
    send_and_wait(8'h55);
    c1 = strobe_cnt;
    n_checks++; if (byte_strobe !== 1'b1) $display("FAIL abort_strobe byte_strobe=%b exp=1", byte_strobe); else n_pass++;
    n_checks++; if (locked_out !== 1'b0) $display("FAIL abort_locked locked_out=%b exp=0", locked_out); else n_pass++;
    send_and_wait(8'h00);
    send_and_wait(8'h00);
    n_checks++; if (byte_strobe !== 1'b0) $display("FAIL abort_nostrobe byte_strobe=%b exp=0", byte_strobe); else n_pass++;
    n_checks++; if (strobe_cnt - c1 !== 1) $display("FAIL abort_strobe_cnt count=%0d exp=1", strobe_cnt - c1); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      send_and_wait(8'hBC);
      n_checks++; if (locked_out !== (k == 4)) $display("FAIL relock_c%0d locked_out=%b exp=%b", k, locked_out, (k == 4)); else n_pass++;
    end
  endtask

  task automatic test_active_lose();
    logic [7:0] e;
    send_and_wait(8'h7C);
    exp_q.push_back(8'h5A);
    send_and_wait(8'h5A);
    e = exp_q.pop_front();
    last_payload = e;
    n_checks++; if (data_out !== e) $display("FAIL lose_data data_out=%h exp=%h", data_out, e); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      send_and_wait(8'hBC);
      n_checks++; if (active_out !== 1'b1) $display("FAIL lose_first_c%0d active_out=%b exp=1", k, active_out); else n_pass++;
      n_checks++; if (valid_out !== 1'b0) $display("FAIL lose_valid_c%0d valid_out=%b exp=0", k, valid_out); else n_pass++;
    end
    n_checks++; if (data_out !== last_payload) $display("FAIL lose_retain data_out=%h exp=%h", data_out, last_payload); else n_pass++;
    send_and_wait(8'h7C);
    n_checks++; if (active_out !== 1'b1) $display("FAIL lose_idle active_out=%b exp=1", active_out); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      send_and_wait(8'hBC);
      n_checks++; if (active_out !== (k != 4)) $display("FAIL lose_second_c%0d active_out=%b exp=%b", k, active_out, (k != 4)); else n_pass++;
    end
    n_checks++; if (locked_out !== 1'b1) $display("FAIL lose_locked locked_out=%b exp=1", locked_out); else n_pass++;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL lose_valid valid_out=%b exp=0", valid_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic [7:0] e;
    send_and_wait(8'h7C);
    for (int k = 0; k < 10; k++) begin
      if (k == 5) b = 8'h7C;
      else begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hBC || b == 8'h7C);
        exp_q.push_back(b);
      end
      send_and_wait(b);
      if (b == 8'h7C) begin
        n_checks++; if (valid_out !== 1'b0) $display("FAIL b2b_idle_valid valid_out=%b exp=0", valid_out); else n_pass++;
        n_checks++; if (data_out !== last_payload) $display("FAIL b2b_idle_data data_out=%h exp=%h", data_out, last_payload); else n_pass++;
      end else begin
        e = exp_q.pop_front();
        last_payload = e;
        n_checks++; if (data_out !== e || valid_out !== 1'b1) $display("FAIL b2b_data%0d data_out=%h valid=%b exp=%h valid=1", k, data_out, valid_out, e); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] e;
    logic [7:0] nb;
    nb = 8'h81;
    exp_q.push_back(8'hC3);
    send_and_wait(8'hC3);
    e = exp_q.pop_front();
    n_checks++; if (data_out !== e) $display("FAIL mid_pre data_out=%h exp=%h", data_out, e); else n_pass++;
    for (int i = 7; i >= 4; i--) send_bit(nb[i]);
    hold_en = 1'b0;
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b1;
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
    n_checks++; if (data_out !== 8'h00) $display("FAIL mid_data data_out=%h exp=00", data_out); else n_pass++;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL mid_valid valid_out=%b exp=0", valid_out); else n_pass++;
    n_checks++; if (byte_strobe !== 1'b0) $display("FAIL mid_strobe byte_strobe=%b exp=0", byte_strobe); else n_pass++;
    n_checks++; if (locked_out !== 1'b0) $display("FAIL mid_locked locked_out=%b exp=0", locked_out); else n_pass++;
    n_checks++; if (active_out !== 1'b0) $display("FAIL mid_active active_out=%b exp=0", active_out); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      send_and_wait(8'hBC);
      hold_en = 1'b1;
      n_checks++; if (locked_out !== (k == 4)) $display("FAIL mid_relock_c%0d locked_out=%b exp=%b", k, locked_out, (k == 4)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_random_phase();
    test_payload();
    test_locking_abort();
    test_active_lose();
    test_back_to_back();
    test_reset_mid_byte();
    n_checks++; if (exp_q.size() !== 0) $display("FAIL queue_empty left=%0d exp=0", exp_q.size()); else n_pass++;
    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
